// File: rtl/uart_mmio_peripheral.sv
// 8N1 UART responder: registered TX serialiser, 2-FF synchronised RX deserialiser and show-ahead RX FIFO.
// TX has no queueing (strobes while busy are dropped); RX bytes arriving while the FIFO is full are dropped and flagged.
module uart_mmio_peripheral #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] uart_tx_data,
  input  logic       uart_tx_we,
  output logic       uart_tx_busy,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  input  logic       uart_rx_re,
  input  logic       err_clr,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       uart_rxd,
  output logic       uart_txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state     <= S_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
    end else if (tx_state == S_IDLE) begin
      if (uart_tx_we) begin
        tx_shift     <= uart_tx_data;
        tx_cnt       <= '0;
        tx_bit       <= '0;
        uart_txd     <= 1'b0;
        uart_tx_busy <= 1'b1;
        tx_state     <= S_START;
      end
    end else if (tx_cnt != BIT_LAST) begin
      tx_cnt <= tx_cnt + CW'(1);
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        S_START: begin
          uart_txd <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_state <= S_DATA;
        end
        S_DATA: begin
          if (tx_bit == 3'd7) begin
            uart_txd <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        end
        default: begin
          uart_tx_busy <= 1'b0;
          tx_state     <= S_IDLE;
        end
      endcase
    end
  end

  logic rxd_meta, rxd_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_push, rx_ferr;

  // rx_push/rx_ferr are one-cycle event pulses consumed by the FIFO and flag logic
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!rxd_sync) rx_state <= S_START;
        end
        S_START: begin
          if (rx_cnt != HALF_LAST) rx_cnt <= rx_cnt + CW'(1);
          else begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_sync ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt != BIT_LAST) rx_cnt <= rx_cnt + CW'(1);
          else begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end
        end
        default: begin
          if (rx_cnt != BIT_LAST) rx_cnt <= rx_cnt + CW'(1);
          else begin
            rx_cnt   <= '0;
            rx_push  <= rxd_sync;
            rx_ferr  <= !rxd_sync;
            rx_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_pop, fifo_push;

  assign fifo_full     = (fifo_cnt == FIFO_FULL);
  assign uart_rx_valid = (fifo_cnt != '0);
  assign fifo_pop      = uart_rx_re && uart_rx_valid;
  // a simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign fifo_push     = rx_push && (!fifo_full || fifo_pop);
  assign uart_rx_data  = uart_rx_valid ? fifo_mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (rx_push && !fifo_push) rx_overrun <= 1'b1;
      else if (err_clr)          rx_overrun <= 1'b0;
      if (rx_ferr)      rx_frame_err <= 1'b1;
      else if (err_clr) rx_frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// Directed bench for uart_mmio_peripheral at CLKS_PER_BIT=16, RX_FIFO_DEPTH=4 with a byte scoreboard on the RX side.
module tb_uart_mmio_peripheral;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, tx_we, rx_re, err_clr, txd, busy, rx_valid, overrun, frame_err;
  logic       rxd_drv, loopback;
  logic [7:0] tx_data, rx_data;
  wire        rxd = loopback ? txd : rxd_drv;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb_q[$];
  int         model_cnt;
  logic       exp_overrun;

  always #5 clk = ~clk;

  uart_mmio_peripheral #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_tx_data(tx_data), .uart_tx_we(tx_we), .uart_tx_busy(busy),
    .uart_rx_data(rx_data), .uart_rx_valid(rx_valid), .uart_rx_re(rx_re),
    .err_clr(err_clr), .rx_overrun(overrun), .rx_frame_err(frame_err),
    .uart_rxd(rxd), .uart_txd(txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe a byte at the current negedge and watch 176 cycles of TX output.
  task automatic tx_capture(input logic [7:0] b, input bit inject, output logic [9:0] frame,
                            output int busy_n, output int level_err);
    logic [9:0] expf;
    expf      = {1'b1, b, 1'b0};
    frame     = '0;
    busy_n    = 0;
    level_err = 0;
    tx_data   = b;
    tx_we     = 1'b1;
    for (int k = 0; k < 176; k++) begin
      @(negedge clk);
      tx_we = 1'b0;
      if (inject && k == 40) begin
        tx_we   = 1'b1;
        tx_data = 8'hFF;
      end
      if (busy === 1'b1) busy_n++;
      if (k < 160) begin
        if (txd !== expf[k / CPB]) level_err++;
        if (k % CPB == CPB / 2) frame[k / CPB] = txd;
      end else if (txd !== 1'b1) begin
        level_err++;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (CPB) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Reference FIFO occupancy: decides whether a good frame should land or overrun.
  task automatic model_rx(input logic [7:0] b);
    if (model_cnt < DEPTH) begin
      sb_q.push_back(b);
      model_cnt++;
    end else begin
      exp_overrun = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    logic [7:0] exp_b;
    int         busy_n, level_err;
    bit         ok;

    rst_n = 1'b0; tx_we = 1'b0; tx_data = '0; rx_re = 1'b0; err_clr = 1'b0;
    rxd_drv = 1'b1; loopback = 1'b0; model_cnt = 0; exp_overrun = 1'b0;

    // 1: reset held with a toggling rxd
    for (int i = 0; i < 3; i++) begin
      rxd_drv = ~rxd_drv;
      @(negedge clk);
      check("rst_txd", 32'(txd), 32'(1));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_valid", 32'(rx_valid), 32'(0));
      check("rst_rx_data", 32'(rx_data), 32'(0));
      check("rst_overrun", 32'(overrun), 32'(0));
      check("rst_frame_err", 32'(frame_err), 32'(0));
    end
    rxd_drv = 1'b1;
    rst_n   = 1'b1;
    repeat (4) @(negedge clk);

    // 2: TX 0xA5 with an ignored strobe of 0xFF during the frame
    tx_capture(8'hA5, 1'b1, frame, busy_n, level_err);
    check("tx_a5_frame", 32'(frame), 32'({1'b1, 8'hA5, 1'b0}));
    check("tx_a5_busy_cycles", 32'(busy_n), 32'(160));
    check("tx_a5_level_errors", 32'(level_err), 32'(0));
    check("tx_ff_ignored_busy", 32'(busy), 32'(0));

    // 3: loopback 0x3C
    loopback = 1'b1;
    model_rx(8'h3C);
    tx_capture(8'h3C, 1'b0, frame, busy_n, level_err);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (rx_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    check("lb_valid_wait", 32'(ok), 32'(1));
    check("lb_sb_nonempty", 32'(sb_q.size()), 32'(1));
    exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    model_cnt--;
    check("lb_rx_data", 32'(rx_data), 32'(exp_b));
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
    check("lb_valid_after_pop", 32'(rx_valid), 32'(0));
    loopback = 1'b0;
    repeat (4) @(negedge clk);

    // 4: five frames without reads, fifth overruns
    for (int b = 1; b <= 5; b++) begin
      model_rx(8'(b));
      send_frame(8'(b), 1'b1);
    end
    check("ovr_flag", 32'(overrun), 32'(exp_overrun));
    check("ovr_frame_err_clear", 32'(frame_err), 32'(0));
    while (sb_q.size() > 0) begin
      exp_b = sb_q.pop_front();
      model_cnt--;
      check("ovr_pop_valid", 32'(rx_valid), 32'(1));
      check("ovr_pop_data", 32'(rx_data), 32'(exp_b));
      rx_re = 1'b1;
      @(negedge clk);
      rx_re = 1'b0;
    end
    check("ovr_drained", 32'(rx_valid), 32'(0));
    check("ovr_sticky", 32'(overrun), 32'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'(0));

    // 5: bad stop bit, then a short glitch
    send_frame(8'h55, 1'b0);
    check("ferr_flag", 32'(frame_err), 32'(1));
    check("ferr_no_push", 32'(rx_valid), 32'(0));
    check("ferr_no_overrun", 32'(overrun), 32'(0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ferr_cleared", 32'(frame_err), 32'(0));
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_push", 32'(rx_valid), 32'(0));
    check("glitch_no_ferr", 32'(frame_err), 32'(0));
    check("glitch_no_overrun", 32'(overrun), 32'(0));

    // 6: reset during TX data bit 3, then a clean frame
    tx_data = 8'h96;
    tx_we   = 1'b1;
    @(negedge clk);
    tx_we = 1'b0;
    repeat (70) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_txd", 32'(txd), 32'(1));
    check("midrst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    tx_capture(8'h5A, 1'b0, frame, busy_n, level_err);
    check("post_rst_frame", 32'(frame), 32'({1'b1, 8'h5A, 1'b0}));
    check("post_rst_busy_cycles", 32'(busy_n), 32'(160));
    check("post_rst_level_errors", 32'(level_err), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
